io_bus_ctrl: RTL and testbench
==============================

// Module: io_bus_ctrl
// PURPOSE
//   Parametrised memory-mapped IO bus controller between the CPU load/store path and NUM_DEV
//   peripherals: LED, seven-segment display, switches, keyboard and future devices.
//   - Decodes the IO window and selects one device.
//   - Handshakes with that device through a req/ack pair and returns read data or an error.
//   - Holds the CPU with cpu_busy until the access completes.
//   - Successor to the fixed single-cycle memory/IO mux: supports multi-cycle devices,
//     N channels and a timeout.
// PARAMETERS
//   ADDR_W         32             CPU address width
//   DATA_W         32             data width
//   NUM_DEV        4              number of device channels, 1..16
//   BASE_ADDR      32'hFFFF_FC00  IO window base, aligned to 2^(DEV_SPAN_LOG2+4)
//   DEV_SPAN_LOG2  4              log2 bytes per device slot (16 B)
//   TIMEOUT        255            max cycles waiting for dev_ack before error, >=1
// PORTS
//   clk        in   1                 system clock
//   rstn       in   1                 asynchronous active-low reset
//   cpu_req    in   1                 IO access request, sampled in IDLE only
//   cpu_we     in   1                 1 = write, 0 = read
//   cpu_addr   in   ADDR_W            byte address
//   cpu_wdata  in   DATA_W            write data
//   cpu_rdata  out  DATA_W            read data, valid while cpu_ready=1
//   cpu_ready  out  1                 one-cycle completion pulse
//   cpu_err    out  1                 qualifies cpu_ready: decode miss or timeout
//   cpu_busy   out  1                 access in flight (state != IDLE); stalls PC
//   dev_sel    out  NUM_DEV           one-hot device select, held until ack or timeout
//   dev_we     out  1                 latched write enable
//   dev_addr   out  DEV_SPAN_LOG2     latched offset within the device slot
//   dev_wdata  out  DATA_W            latched write data
//   dev_rdata  in   NUM_DEV*DATA_W    flattened read data; device i owns bits [i*DATA_W +: DATA_W]
//   dev_ack    in   NUM_DEV           per-device completion, may assert in the first select cycle
//   err_count  out  8                 saturating count of error completions
// BEHAVIOUR
//   Reset (rstn=0, async): state=IDLE; every output 0; timeout counter=0; err_count=0.
//   Decode:
//     - hit iff cpu_addr[ADDR_W-1:DEV_SPAN_LOG2+4] == BASE_ADDR[same bits]
//       and idx = cpu_addr[DEV_SPAN_LOG2+3:DEV_SPAN_LOG2] < NUM_DEV.
//   FSM IDLE -> ACCESS -> RESP -> IDLE; ERR for misses:
//     IDLE:
//       - cpu_req & hit: latch we/addr offset/wdata/idx; -> ACCESS.
//       - cpu_req & miss: -> ERR.
//     ACCESS:
//       - dev_sel[idx]=1; counter increments every cycle.
//       - dev_ack[idx]=1: latch dev_rdata slice idx into cpu_rdata (0 on writes); -> RESP.
//       - else counter==TIMEOUT: -> RESP with err; cpu_rdata=0.
//     RESP/ERR: cpu_ready=1 for exactly one cycle; cpu_err=1 on ERR or timeout;
//               dev_sel=0; -> IDLE.
//   Latency (req sampled in cycle 0):
//     - hit with ack in cycle k>=1: dev_sel cycles 1..k, cpu_ready in cycle k+1.
//     - miss: cpu_ready+cpu_err in cycle 1.
//     - timeout: cpu_ready in cycle TIMEOUT+1.
//   Boundary rules:
//     - ack and timeout in the same cycle: ack wins, no error.
//     - dev_ack from non-selected devices: ignored.
//     - ack outside ACCESS: ignored.
//     - cpu_req while busy: ignored; the CPU holds the request until cpu_ready.
//     - cpu_req=1 in the cycle after RESP: starts a new access (back-to-back is legal).
//     - err_count increments on every cpu_err pulse and saturates at 8'hFF.
//     - dev_we/dev_addr/dev_wdata stay stable for the whole ACCESS state.
//     - reset mid-access: immediate return to IDLE, no cpu_ready pulse.
// STRUCTURE
//   Shared package io_bus_pkg:
//     - state enum (IDLE, ACCESS, RESP, ERR).
//     - default BASE_ADDR.
//     - device index constants DEV_LED=0, DEV_SEG=1, DEV_SW=2, DEV_KBD=3.
//   One combinational sub-module io_addr_decode: outputs hit and idx from cpu_addr.
//   FSM, latches and counters live in io_bus_ctrl.
// TESTING
//   1. Read SW (idx 2) at 0xFFFF_FC20, dev_rdata slice2=0x0000_0ABC, ack in cycle 1
//      -> dev_sel=4'b0100 in cycle 1; cpu_ready in cycle 2 with cpu_rdata=0xABC, cpu_err=0.
//   2. Write 0x1234 to LED at 0xFFFF_FC04, ack delayed to cycle 5
//      -> dev_we=1, dev_addr=4, dev_wdata=0x1234 stable in cycles 1..5; cpu_ready in cycle 6.
//   3. Request to 0xFFFF_FC40 (idx 4 >= NUM_DEV) and to 0x0000_1000
//      -> dev_sel stays 0; cpu_ready+cpu_err in cycle 1; err_count increments to 1, then 2.
//   4. Read KBD, no ack, TIMEOUT=8
//      -> cpu_ready+cpu_err in cycle 9, cpu_rdata=0; ack on dev 1 during the wait is ignored.
//   5. Ack arrives in the same cycle the counter reaches TIMEOUT -> cpu_err=0, data returned;
//      a back-to-back req the cycle after cpu_ready is accepted.
//   6. rstn low during ACCESS -> all outputs 0 asynchronously; no cpu_ready pulse;
//      err_count=0; the next request behaves as in test 1.

Source files
------------

// File: rtl/io_bus_pkg.sv
// Shared types and constants for the memory-mapped IO bus controller.
package io_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } bus_state_t;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_FC00;

  // Slot index of each peripheral inside the IO window
  localparam int DEV_LED = 0;
  localparam int DEV_SEG = 1;
  localparam int DEV_SW  = 2;
  localparam int DEV_KBD = 3;

  // Width needed to hold a device index for n channels
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_bus_if.sv
// CPU-side and device-side signals of the IO bus.
// slave  : the controller, serving CPU requests and driving the device channels.
// master : the environment, i.e. the CPU load/store path plus the peripherals.
interface io_bus_if #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int NUM_DEV       = 4,
  parameter int DEV_SPAN_LOG2 = 4
);

  logic                      cpu_req;
  logic                      cpu_we;
  logic [ADDR_W-1:0]         cpu_addr;
  logic [DATA_W-1:0]         cpu_wdata;
  logic [DATA_W-1:0]         cpu_rdata;
  logic                      cpu_ready;
  logic                      cpu_err;
  logic                      cpu_busy;
  logic [NUM_DEV-1:0]        dev_sel;
  logic                      dev_we;
  logic [DEV_SPAN_LOG2-1:0]  dev_addr;
  logic [DATA_W-1:0]         dev_wdata;
  logic [NUM_DEV*DATA_W-1:0] dev_rdata;
  logic [NUM_DEV-1:0]        dev_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dev_rdata, dev_ack,
    output cpu_rdata, cpu_ready, cpu_err, cpu_busy,
           dev_sel, dev_we, dev_addr, dev_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, dev_rdata, dev_ack,
    input  cpu_rdata, cpu_ready, cpu_err, cpu_busy,
           dev_sel, dev_we, dev_addr, dev_wdata
  );

endinterface

// File: rtl/io_addr_decode.sv
// IO window decoder: flags a hit and yields the device slot index.
// Only the address bits above the in-slot offset are needed here.
module io_addr_decode
  import io_bus_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter int                NUM_DEV       = 4,
  parameter int                DEV_SPAN_LOG2 = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int                IDX_W         = idx_width(NUM_DEV)
) (
  input  logic [ADDR_W-1:DEV_SPAN_LOG2] addr,
  output logic                          hit,
  output logic [IDX_W-1:0]              idx
);

  localparam int WIN_LSB = DEV_SPAN_LOG2 + 4;

  logic [3:0] slot;

  // Window compare on the upper bits, slot range check against NUM_DEV
  always_comb begin
    slot = addr[WIN_LSB-1:DEV_SPAN_LOG2];
    hit  = (addr[ADDR_W-1:WIN_LSB] == BASE_ADDR[ADDR_W-1:WIN_LSB]) &&
           ({1'b0, slot} < 5'(NUM_DEV));
    idx  = IDX_W'(slot);
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// IO bus controller: decodes CPU IO accesses, handshakes with one device
// through req/ack, returns read data or an error, and stalls the CPU meanwhile.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for cpu_req; decode sampled here only
//   ACCESS | dev_sel asserted, waiting for ack or the timeout count
//   RESP   | one-cycle cpu_ready; cpu_err set if the access timed out
//   ERR    | one-cycle cpu_ready + cpu_err for an address decode miss
module io_bus_ctrl
  import io_bus_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                NUM_DEV       = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = ADDR_W'(DEFAULT_BASE_ADDR),
  parameter int                DEV_SPAN_LOG2 = 4,
  parameter int                TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rstn,
  io_bus_if.slave     bus,
  output logic [7:0]  err_count
);

  localparam int IDX_W = idx_width(NUM_DEV);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  bus_state_t                state, state_d;
  logic                      hit;
  logic [IDX_W-1:0]          dec_idx;
  logic                      we_q;
  logic [DEV_SPAN_LOG2-1:0]  addr_q;
  logic [DATA_W-1:0]         wdata_q;
  logic [IDX_W-1:0]          idx_q;
  logic [DATA_W-1:0]         rdata_q;
  logic                      err_q;
  logic [CNT_W-1:0]          cnt_q;
  logic                      ack_sel;
  logic                      timeout_hit;
  logic [NUM_DEV-1:0]        sel;
  logic                      ready;
  logic                      err;

  io_addr_decode #(
    .ADDR_W        (ADDR_W),
    .NUM_DEV       (NUM_DEV),
    .DEV_SPAN_LOG2 (DEV_SPAN_LOG2),
    .BASE_ADDR     (BASE_ADDR),
    .IDX_W         (IDX_W)
  ) u_decode (
    .addr (bus.cpu_addr[ADDR_W-1:DEV_SPAN_LOG2]),
    .hit  (hit),
    .idx  (dec_idx)
  );

  // The counter holds k during the k-th ACCESS cycle, so reaching TIMEOUT
  // puts the response in cycle TIMEOUT+1 after the request.
  assign ack_sel     = bus.dev_ack[idx_q];
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state and per-state outputs
  always_comb begin
    state_d = state;
    sel     = '0;
    ready   = 1'b0;
    err     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cpu_req) state_d = hit ? ACCESS : ERR;
      end
      ACCESS: begin
        sel[idx_q] = 1'b1;
        if (ack_sel || timeout_hit) state_d = RESP;
      end
      RESP: begin
        ready   = 1'b1;
        err     = err_q;
        state_d = IDLE;
      end
      ERR: begin
        ready   = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latches, timeout counter and response capture; ack beats timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
            if (hit) begin
              we_q    <= bus.cpu_we;
              addr_q  <= bus.cpu_addr[DEV_SPAN_LOG2-1:0];
              wdata_q <= bus.cpu_wdata;
              idx_q   <= dec_idx;
              cnt_q   <= CNT_W'(1);
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (ack_sel) begin
            rdata_q <= we_q ? '0 : bus.dev_rdata[int'(idx_q)*DATA_W +: DATA_W];
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Saturating count of error completions
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                         err_count <= 8'h00;
    else if (err && err_count != 8'hFF) err_count <= err_count + 8'h01;
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_ready = ready;
  assign bus.cpu_err   = err;
  assign bus.cpu_busy  = (state != IDLE);
  assign bus.dev_sel   = sel;
  assign bus.dev_we    = we_q;
  assign bus.dev_addr  = addr_q;
  assign bus.dev_wdata = wdata_q;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Self-checking bench for io_bus_ctrl. Responses are predicted when a request
// is driven and checked by a scoreboard monitor when cpu_ready appears.
module tb_io_bus_ctrl;
  import io_bus_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NUM_DEV = 4;
  localparam int SPAN    = 4;
  localparam int TMO     = 8;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] err_count;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         err_model = 0;
  exp_t       sb_q[$];
  exp_t       mon_e;

  io_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_DEV(NUM_DEV), .DEV_SPAN_LOG2(SPAN)) bus ();

  io_bus_ctrl #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .NUM_DEV       (NUM_DEV),
    .BASE_ADDR     (32'hFFFF_FC00),
    .DEV_SPAN_LOG2 (SPAN),
    .TIMEOUT       (TMO)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstn && bus.cpu_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ready: cpu_ready=1 at cycle %0d, required no response", cyc);
      end else begin
        mon_e = sb_q.pop_front();
        checks += 3;
        if (bus.cpu_rdata !== mon_e.rdata) begin
          failures++;
          $display("FAIL resp_rdata: got %h expected %h", bus.cpu_rdata, mon_e.rdata);
        end
        if (bus.cpu_err !== mon_e.err) begin
          failures++;
          $display("FAIL resp_err: got %b expected %b", bus.cpu_err, mon_e.err);
        end
        if (cyc != mon_e.cyc) begin
          failures++;
          $display("FAIL resp_cycle: got %0d expected %0d", cyc, mon_e.cyc);
        end
        if (mon_e.err && err_model != 255) err_model++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks += 4;
    if (bus.cpu_ready !== 1'b0 || bus.cpu_err !== 1'b0 || bus.cpu_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_cpu: got ready=%b err=%b busy=%b expected 0 0 0",
               bus.cpu_ready, bus.cpu_err, bus.cpu_busy);
    end
    if (bus.dev_sel !== 4'b0000 || bus.dev_we !== 1'b0) begin
      failures++;
      $display("FAIL reset_dev: got sel=%b we=%b expected 0000 0", bus.dev_sel, bus.dev_we);
    end
    if (bus.dev_addr !== 4'h0 || bus.dev_wdata !== 32'h0 || bus.cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected 0",
               bus.dev_addr, bus.dev_wdata, bus.cpu_rdata);
    end
    if (err_count !== 8'h00) begin
      failures++;
      $display("FAIL reset_errcnt: got %h expected 00", err_count);
    end
    err_model = 0;
    rstn = 1'b1;
  endtask

  task automatic test_read_sw();
    int n;
    @(negedge clk);
    n = cyc;
    bus.dev_rdata = {32'hC0DE_0003, 32'h0000_0ABC, 32'hC0DE_0001, 32'hC0DE_0000};
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'hFFFF_FC20;
    bus.cpu_wdata = 32'h0;
    bus.cpu_req   = 1'b1;
    sb_q.push_back('{rdata: 32'h0000_0ABC, err: 1'b0, cyc: n + 2});
    @(negedge clk);
    checks += 2;
    if (bus.dev_sel !== 4'b0100) begin
      failures++;
      $display("FAIL sw_sel: got %b expected 0100", bus.dev_sel);
    end
    if (bus.cpu_busy !== 1'b1) begin
      failures++;
      $display("FAIL sw_busy: got %b expected 1", bus.cpu_busy);
    end
    bus.dev_ack = 4'b0100;
    @(negedge clk);
    checks++;
    if (bus.dev_sel !== 4'b0000) begin
      failures++;
      $display("FAIL sw_sel_resp: got %b expected 0000", bus.dev_sel);
    end
    bus.dev_ack = 4'b0000;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks += 2;
    if (bus.cpu_busy !== 1'b0) begin
      failures++;
      $display("FAIL sw_idle: got busy=%b expected 0", bus.cpu_busy);
    end
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sw_drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  task automatic test_write_led();
    int n;
    @(negedge clk);
    n = cyc;
    bus.dev_rdata = {32'h0, 32'h0, 32'h0, 32'hBAD0_0000};
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'hFFFF_FC04;
    bus.cpu_wdata = 32'h0000_1234;
    bus.cpu_req   = 1'b1;
    sb_q.push_back('{rdata: 32'h0, err: 1'b0, cyc: n + 6});
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks += 2;
      if (bus.dev_sel !== 4'b0001) begin
        failures++;
        $display("FAIL led_sel c%0d: got %b expected 0001", k, bus.dev_sel);
      end
      if (bus.dev_we !== 1'b1 || bus.dev_addr !== 4'h4 || bus.dev_wdata !== 32'h0000_1234) begin
        failures++;
        $display("FAIL led_hold c%0d: got we=%b addr=%h wdata=%h expected 1 4 00001234",
                 k, bus.dev_we, bus.dev_addr, bus.dev_wdata);
      end
      if (k == 1) begin
        bus.cpu_wdata = 32'hDEAD_BEEF;
        bus.cpu_addr  = 32'hFFFF_FC28;
        bus.cpu_we    = 1'b0;
      end
      if (k == 2) bus.dev_ack = 4'b0010;
      if (k == 3) bus.dev_ack = 4'b0000;
      if (k == 5) bus.dev_ack = 4'b0001;
    end
    @(negedge clk);
    bus.dev_ack = 4'b0000;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL led_drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  task automatic test_decode_miss();
    logic [31:0] addrs [2];
    int n;
    addrs[0] = 32'hFFFF_FC40;
    addrs[1] = 32'h0000_1000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n = cyc;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = addrs[i];
      bus.cpu_req  = 1'b1;
      sb_q.push_back('{rdata: 32'h0, err: 1'b1, cyc: n + 1});
      @(negedge clk);
      checks++;
      if (bus.dev_sel !== 4'b0000) begin
        failures++;
        $display("FAIL miss_sel %0d: got %b expected 0000", i, bus.dev_sel);
      end
      bus.cpu_req = 1'b0;
      @(negedge clk);
      checks++;
      if (err_count !== 8'(i + 1)) begin
        failures++;
        $display("FAIL miss_errcnt %0d: got %0d expected %0d", i, err_count, i + 1);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    @(negedge clk);
    bus.dev_ack = 4'b1000;
    @(negedge clk);
    checks++;
    if (bus.cpu_busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_ack: got busy=%b expected 0", bus.cpu_busy);
    end
    bus.dev_ack = 4'b0000;
    n = cyc;
    bus.dev_rdata = {32'h7777_7777, 32'h0, 32'h0, 32'h0};
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'hFFFF_FC30;
    bus.cpu_req   = 1'b1;
    sb_q.push_back('{rdata: 32'h0, err: 1'b1, cyc: n + TMO + 1});
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      checks++;
      if (bus.dev_sel !== 4'b1000) begin
        failures++;
        $display("FAIL tmo_sel c%0d: got %b expected 1000", k, bus.dev_sel);
      end
      if (k == 3) bus.dev_ack = 4'b0010;
    end
    @(negedge clk);
    checks++;
    if (bus.dev_sel !== 4'b0000) begin
      failures++;
      $display("FAIL tmo_sel_resp: got %b expected 0000", bus.dev_sel);
    end
    bus.dev_ack = 4'b0000;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks += 2;
    if (err_count !== 8'(err_model)) begin
      failures++;
      $display("FAIL tmo_errcnt: got %0d expected %0d", err_count, err_model);
    end
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL tmo_drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    n = cyc;
    bus.dev_rdata = {32'h0, 32'h0, 32'h5EC0_0018, 32'h1ED0_0001};
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'hFFFF_FC18;
    bus.cpu_req   = 1'b1;
    sb_q.push_back('{rdata: 32'h5EC0_0018, err: 1'b0, cyc: n + TMO + 1});
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      checks++;
      if (bus.dev_addr !== 4'h8) begin
        failures++;
        $display("FAIL b2b_addr c%0d: got %h expected 8", k, bus.dev_addr);
      end
      if (k == TMO) bus.dev_ack = 4'b0010;
    end
    @(negedge clk);
    bus.dev_ack  = 4'b0000;
    bus.cpu_addr = 32'hFFFF_FC00;
    sb_q.push_back('{rdata: 32'h1ED0_0001, err: 1'b0, cyc: n + TMO + 4});
    @(negedge clk);
    checks++;
    if (bus.cpu_busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got busy=%b expected 0", bus.cpu_busy);
    end
    @(negedge clk);
    checks++;
    if (bus.dev_sel !== 4'b0001) begin
      failures++;
      $display("FAIL b2b_sel: got %b expected 0001", bus.dev_sel);
    end
    bus.dev_ack = 4'b0001;
    @(negedge clk);
    bus.dev_ack = 4'b0000;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    checks += 2;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: got %0d pending expected 0", sb_q.size());
    end
    if (err_count !== 8'(err_model)) begin
      failures++;
      $display("FAIL b2b_errcnt: got %0d expected %0d", err_count, err_model);
    end
  endtask

  task automatic test_err_saturate();
    for (int i = 0; i < 260; i++) begin
      @(negedge clk);
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 32'h0000_1000;
      bus.cpu_req  = 1'b1;
      sb_q.push_back('{rdata: 32'h0, err: 1'b1, cyc: cyc + 1});
      @(negedge clk);
      bus.cpu_req = 1'b0;
    end
    @(negedge clk);
    checks += 2;
    if (err_count !== 8'hFF || err_model != 255) begin
      failures++;
      $display("FAIL sat_errcnt: got %0d expected 255 (model %0d)", err_count, err_model);
    end
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sat_drain: got %0d pending expected 0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 32'hFFFF_FC2C;
    bus.cpu_wdata = 32'h0000_CAFE;
    bus.cpu_req   = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.cpu_busy !== 1'b1 || bus.dev_sel !== 4'b0100) begin
      failures++;
      $display("FAIL mid_access: got busy=%b sel=%b expected 1 0100", bus.cpu_busy, bus.dev_sel);
    end
    rstn = 1'b0;
    #1;
    checks += 3;
    if (bus.cpu_busy !== 1'b0 || bus.dev_sel !== 4'b0000 || bus.cpu_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_rst_ctl: got busy=%b sel=%b ready=%b expected 0 0000 0",
               bus.cpu_busy, bus.dev_sel, bus.cpu_ready);
    end
    if (bus.dev_we !== 1'b0 || bus.dev_addr !== 4'h0 || bus.dev_wdata !== 32'h0) begin
      failures++;
      $display("FAIL mid_rst_dev: got we=%b addr=%h wdata=%h expected 0 0 0",
               bus.dev_we, bus.dev_addr, bus.dev_wdata);
    end
    if (err_count !== 8'h00) begin
      failures++;
      $display("FAIL mid_rst_errcnt: got %0d expected 0", err_count);
    end
    err_model   = 0;
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    test_read_sw();
  endtask

  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dev_rdata = '0;
    bus.dev_ack   = '0;
    test_reset();
    test_read_sw();
    test_write_led();
    test_decode_miss();
    test_timeout();
    test_back_to_back();
    test_err_saturate();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
